// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM state enum, opcode constants and datapath mux-select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECR    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    ALUWB    = 4'd10,
    BEQ      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Any opcode outside the supported subset lands in TRAP.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_next = MEMADR;
      OP_RTYPE:          decode_next = EXECR;
      OP_ITYPE:          decode_next = EXECI;
      OP_JAL:            decode_next = JAL;
      OP_BEQ:            decode_next = BEQ;
      default:           decode_next = TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The master side is the control
// unit; the slave side is the datapath plus memory it steers.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       retire;
  logic       trap;
  logic       trap_cause;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, retire, trap, trap_cause,
           state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, retire, trap, trap_cause,
           state_dbg
  );
endinterface

// File: rtl/multicycle_control_unit_timer.sv
// Memory wait timer: counts cycles a request waits for mem_ready and flags
// the cycle in which the count would reach TIMEOUT_CYCLES.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry is the waiting cycle whose increment reaches the limit, so a
  // same-cycle mem_ready (which suppresses i_inc) always wins.
  assign o_expired = i_inc && (r_count == LIMIT_M1);

endmodule

// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM of the multicycle RV32I core: steers PC, IR, shared
// memory, register file and ALU; traps on illegal opcodes and bus timeouts.
module multicycle_control_unit
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_control_unit_if.master     bus
);

  state_t     r_state;
  state_t     w_state_n;
  logic       r_trap;
  logic       r_trap_cause;
  logic       w_trap_cause_n;

  logic       w_mem_req;
  logic       w_memwrite;
  logic       w_adrsrc;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_regwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic       w_retire;

  logic       w_timer_clr;
  logic       w_timer_inc;
  logic       w_expired;

  assign w_mem_req   = (r_state == FETCH) || (r_state == MEMREAD) ||
                       (r_state == MEMWRITE);
  assign w_timer_inc = w_mem_req && !bus.mem_ready;
  assign w_timer_clr = bus.mem_ready ||
                       ((w_state_n != r_state) &&
                        ((w_state_n == FETCH) || (w_state_n == MEMREAD) ||
                         (w_state_n == MEMWRITE)));

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_timer_clr),
    .i_inc     (w_timer_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Trap flag and cause are latched only on the transition into TRAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trap       <= 1'b0;
      r_trap_cause <= 1'b0;
    end else if ((w_state_n == TRAP) && (r_state != TRAP)) begin
      r_trap       <= 1'b1;
      r_trap_cause <= w_trap_cause_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_trap_cause_n = 1'b0;
    w_memwrite     = 1'b0;
    w_adrsrc       = 1'b0;
    w_irwrite      = 1'b0;
    w_pcwrite      = 1'b0;
    w_regwrite     = 1'b0;
    w_resultsrc    = RES_ALUOUT;
    w_alusrca      = SRCA_PC;
    w_alusrcb      = SRCB_RD2;
    w_aluop        = ALUOP_ADD;
    w_retire       = 1'b0;

    case (r_state)
      IDLE: w_state_n = FETCH;

      FETCH: begin
        w_alusrca   = SRCA_PC;
        w_alusrcb   = SRCB_FOUR;
        w_aluop     = ALUOP_ADD;
        w_resultsrc = RES_ALURES;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_state_n = DECODE;
        end else if (w_expired) begin
          w_state_n      = TRAP;
          w_trap_cause_n = 1'b1;
        end
      end

      DECODE: begin
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALUOP_ADD;
        w_state_n = decode_next(bus.opcode);
      end

      MEMADR: begin
        w_alusrca = SRCA_RD1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALUOP_ADD;
        w_state_n = bus.opcode[5] ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        w_adrsrc    = 1'b1;
        w_resultsrc = RES_ALUOUT;
        if (bus.mem_ready) begin
          w_state_n = MEMWB;
        end else if (w_expired) begin
          w_state_n      = TRAP;
          w_trap_cause_n = 1'b1;
        end
      end

      MEMWB: begin
        w_resultsrc = RES_MEMDATA;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        w_state_n   = FETCH;
      end

      MEMWRITE: begin
        w_memwrite  = 1'b1;
        w_adrsrc    = 1'b1;
        w_resultsrc = RES_ALUOUT;
        if (bus.mem_ready) begin
          w_retire  = 1'b1;
          w_state_n = FETCH;
        end else if (w_expired) begin
          w_state_n      = TRAP;
          w_trap_cause_n = 1'b1;
        end
      end

      EXECR: begin
        w_alusrca = SRCA_RD1;
        w_alusrcb = SRCB_RD2;
        w_aluop   = ALUOP_FUNCT;
        w_state_n = ALUWB;
      end

      EXECI: begin
        w_alusrca = SRCA_RD1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALUOP_FUNCT;
        w_state_n = ALUWB;
      end

      JAL: begin
        w_alusrca   = SRCA_OLDPC;
        w_alusrcb   = SRCB_FOUR;
        w_aluop     = ALUOP_ADD;
        w_resultsrc = RES_ALUOUT;
        w_pcwrite   = 1'b1;
        w_state_n   = ALUWB;
      end

      ALUWB: begin
        w_resultsrc = RES_ALUOUT;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        w_state_n   = FETCH;
      end

      BEQ: begin
        w_alusrca   = SRCA_RD1;
        w_alusrcb   = SRCB_RD2;
        w_aluop     = ALUOP_SUB;
        w_resultsrc = RES_ALUOUT;
        w_pcwrite   = bus.zero;
        w_retire    = 1'b1;
        w_state_n   = FETCH;
      end

      TRAP: w_state_n = TRAP;

      default: w_state_n = IDLE;
    endcase
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.memwrite   = w_memwrite;
  assign bus.adrsrc     = w_adrsrc;
  assign bus.irwrite    = w_irwrite;
  assign bus.pcwrite    = w_pcwrite;
  assign bus.regwrite   = w_regwrite;
  assign bus.resultsrc  = w_resultsrc;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.aluop      = w_aluop;
  assign bus.retire     = w_retire;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_trap_cause;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: instruction-level table checks,
// hand-written corner sequences and a randomized instruction stream.
module tb_multicycle_control_unit;

  localparam int TMO = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                 S_MEMREAD = 4, S_MEMWB = 5, S_MEMWRITE = 6, S_EXECR = 7,
                 S_EXECI = 8, S_JAL = 9, S_ALUWB = 10, S_BEQ = 11,
                 S_TRAP = 12;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                         II = 7'b0010011, JJ = 7'b1101111, BB = 7'b1100011,
                         BAD = 7'b0000000;

  typedef struct packed {
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic       retire, trap, trap_cause;
    logic [3:0] st;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    int         wf, wm;
    logic       z;
    int         cyc, ret, regw, memw, pcw, irw;
    logic       trp, cause;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic m_cause = 1'b0;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.mem_req = bus.mem_req;     o.memwrite = bus.memwrite;
    o.adrsrc = bus.adrsrc;       o.irwrite = bus.irwrite;
    o.pcwrite = bus.pcwrite;     o.regwrite = bus.regwrite;
    o.resultsrc = bus.resultsrc; o.alusrca = bus.alusrca;
    o.alusrcb = bus.alusrcb;     o.aluop = bus.aluop;
    o.retire = bus.retire;       o.trap = bus.trap;
    o.trap_cause = bus.trap_cause;
    o.st = bus.state_dbg;
    return o;
  endfunction

  // Expected control word for one cycle, straight from the per-state output list.
  function automatic outs_t exp_vec(input int st, input logic rdy, input logic z, input logic cause);
    outs_t o;
    o = '0;
    o.st = 4'(st);
    case (st)
      S_FETCH:    begin o.mem_req = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                        o.irwrite = rdy; o.pcwrite = rdy; end
      S_DECODE:   begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
      S_MEMADR:   begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
      S_MEMREAD:  begin o.mem_req = 1; o.adrsrc = 1; end
      S_MEMWB:    begin o.resultsrc = 2'b01; o.regwrite = 1; o.retire = 1; end
      S_MEMWRITE: begin o.mem_req = 1; o.memwrite = 1; o.adrsrc = 1; o.retire = rdy; end
      S_EXECR:    begin o.alusrca = 2'b10; o.aluop = 2'b10; end
      S_EXECI:    begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.aluop = 2'b10; end
      S_JAL:      begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1; end
      S_ALUWB:    begin o.regwrite = 1; o.retire = 1; end
      S_BEQ:      begin o.alusrca = 2'b10; o.aluop = 2'b01; o.pcwrite = z; o.retire = 1; end
      S_TRAP:     begin o.trap = 1; o.trap_cause = cause; end
      default:    ;
    endcase
    return o;
  endfunction

  task automatic step(input int st, input logic rdy, input logic [6:0] op);
    logic z;
    @(negedge clk);
    z = 1'($urandom);
    bus.mem_ready = rdy;
    bus.zero = z;
    bus.opcode = op;
    #1;
    chk($sformatf("cycle_state%0d", st), 32'(sample()), 32'(exp_vec(st, rdy, z, m_cause)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk("reset_assert", 32'(sample()), 32'(exp_vec(S_IDLE, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release", 32'(sample()), 32'(exp_vec(S_IDLE, 1'b0, 1'b0, 1'b0)));
    m_cause = 1'b0;
  endtask

  // A waiting phase: w stall cycles then the ready cycle, or a timeout when w reaches the limit.
  task automatic wait_phase(input int st, input int w, input logic [6:0] op, output bit trapped);
    trapped = 0;
    if (w >= TMO) begin
      for (int i = 0; i < TMO; i++) step(st, 1'b0, op);
      trapped = 1;
      m_cause = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) step(st, 1'b0, op);
      step(st, 1'b1, op);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, output bit trapped);
    wait_phase(S_FETCH, wf, op, trapped);
    if (trapped) return;
    step(S_DECODE, 1'($urandom), op);
    case (op)
      LD: begin
        step(S_MEMADR, 1'($urandom), op);
        wait_phase(S_MEMREAD, wm, op, trapped);
        if (!trapped) step(S_MEMWB, 1'($urandom), op);
      end
      ST: begin
        step(S_MEMADR, 1'($urandom), op);
        wait_phase(S_MEMWRITE, wm, op, trapped);
      end
      RR: begin step(S_EXECR, 1'($urandom), op); step(S_ALUWB, 1'($urandom), op); end
      II: begin step(S_EXECI, 1'($urandom), op); step(S_ALUWB, 1'($urandom), op); end
      JJ: begin step(S_JAL, 1'($urandom), op);   step(S_ALUWB, 1'($urandom), op); end
      BB: step(S_BEQ, 1'($urandom), op);
      default: begin trapped = 1; m_cause = 1'b0; end
    endcase
  endtask

  vec_t tbl[11];

  initial begin
    logic [6:0] bad_ops [6];
    bit         trapped;

    tbl[0]  = '{RR,  0, 0, 1'b0, 4, 1, 1, 0, 1, 1, 1'b0, 1'b0};
    tbl[1]  = '{LD,  0, 3, 1'b0, 8, 1, 1, 0, 1, 1, 1'b0, 1'b0};
    tbl[2]  = '{ST,  0, 1, 1'b0, 5, 1, 0, 2, 1, 1, 1'b0, 1'b0};
    tbl[3]  = '{II,  2, 0, 1'b0, 6, 1, 1, 0, 1, 1, 1'b0, 1'b0};
    tbl[4]  = '{JJ,  0, 0, 1'b0, 4, 1, 1, 0, 2, 1, 1'b0, 1'b0};
    tbl[5]  = '{BB,  0, 0, 1'b1, 3, 1, 0, 0, 2, 1, 1'b0, 1'b0};
    tbl[6]  = '{BB,  1, 0, 1'b0, 4, 1, 0, 0, 1, 1, 1'b0, 1'b0};
    tbl[7]  = '{BAD, 0, 0, 1'b0, 2, 0, 0, 0, 1, 1, 1'b1, 1'b0};
    tbl[8]  = '{RR,  4, 0, 1'b0, 4, 0, 0, 0, 0, 0, 1'b1, 1'b1};
    tbl[9]  = '{RR,  3, 0, 1'b0, 7, 1, 1, 0, 1, 1, 1'b0, 1'b0};
    tbl[10] = '{LD,  0, 4, 1'b0, 7, 0, 0, 0, 1, 1, 1'b1, 1'b1};

    bad_ops = '{7'b0000000, 7'b1110011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1111111};

    bus.opcode = RR;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    // Instruction-level table: mem_ready is driven by counting cycles spent in each wait state.
    for (int t = 0; t < 11; t++) begin
      int   fc, mc, cyc, ret, regw, memw, pcw, irw, s;
      bit   left, done;
      logic rdy;
      do_reset();
      fc = 0; mc = 0; cyc = 0; ret = 0; regw = 0; memw = 0; pcw = 0; irw = 0;
      left = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge clk);
        s = int'(bus.state_dbg);
        if (s == S_TRAP || (s == S_FETCH && left)) begin
          done = 1;
        end else begin
          rdy = 1'b0;
          if (s == S_FETCH) begin rdy = (fc == tbl[t].wf); fc++; end
          else if (s == S_MEMREAD || s == S_MEMWRITE) begin rdy = (mc == tbl[t].wm); mc++; end
          bus.mem_ready = rdy;
          bus.zero = tbl[t].z;
          bus.opcode = tbl[t].op;
          #1;
          if (s != S_IDLE) begin
            cyc++;
            if (s != S_FETCH) left = 1;
            ret += int'(bus.retire);
            regw += int'(bus.regwrite);
            memw += int'(bus.memwrite);
            pcw += int'(bus.pcwrite);
            irw += int'(bus.irwrite);
          end
        end
      end
      chk($sformatf("t%0d_completes", t), 32'(done), 32'(1));
      chk($sformatf("t%0d_cycles", t), 32'(cyc), 32'(tbl[t].cyc));
      chk($sformatf("t%0d_retire", t), 32'(ret), 32'(tbl[t].ret));
      chk($sformatf("t%0d_regwrite", t), 32'(regw), 32'(tbl[t].regw));
      chk($sformatf("t%0d_memwrite", t), 32'(memw), 32'(tbl[t].memw));
      chk($sformatf("t%0d_pcwrite", t), 32'(pcw), 32'(tbl[t].pcw));
      chk($sformatf("t%0d_irwrite", t), 32'(irw), 32'(tbl[t].irw));
      chk($sformatf("t%0d_trap", t), 32'(bus.trap), 32'(tbl[t].trp));
      chk($sformatf("t%0d_cause", t), 32'(bus.trap_cause), 32'(tbl[t].cause));
    end

    // R-type with mem_ready tied high: IDLE, FETCH, DECODE, EXECR, ALUWB, FETCH.
    do_reset();
    step(S_FETCH, 1'b1, RR);
    step(S_DECODE, 1'b1, RR);
    step(S_EXECR, 1'b1, RR);
    step(S_ALUWB, 1'b1, RR);
    step(S_FETCH, 1'b1, RR);

    // Illegal opcode: trap holds for 20 cycles regardless of inputs, then reset recovers.
    do_reset();
    run_instr(BAD, 0, 0, trapped);
    chk("illegal_trapped", 32'(trapped), 32'(1));
    for (int i = 0; i < 20; i++) step(S_TRAP, 1'($urandom), 7'($urandom));
    do_reset();
    step(S_FETCH, 1'b1, RR);

    // Reset in the middle of a load wait, then a fresh instruction with a near-limit fetch stall.
    do_reset();
    step(S_FETCH, 1'b1, LD);
    step(S_DECODE, 1'b1, LD);
    step(S_MEMADR, 1'b0, LD);
    step(S_MEMREAD, 1'b0, LD);
    step(S_MEMREAD, 1'b0, LD);
    do_reset();
    run_instr(II, 3, 0, trapped);
    chk("post_reset_no_trap", 32'(trapped), 32'(0));

    // Randomized instruction stream against the cycle-level reference.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      int         sel, wf, wm;
      sel = $urandom_range(0, 13);
      case (sel)
        0, 1, 13: op = LD;
        2, 3:     op = ST;
        4, 5:     op = RR;
        6, 7:     op = II;
        8, 9:     op = JJ;
        10, 11:   op = BB;
        default:  op = bad_ops[$urandom_range(0, 5)];
      endcase
      wf = $urandom_range(0, 11);
      wf = (wf >= 10) ? $urandom_range(TMO, TMO + 2) : wf % TMO;
      wm = $urandom_range(0, 11);
      wm = (wm >= 10) ? TMO : wm % TMO;
      run_instr(op, wf, wm, trapped);
      if (trapped) begin
        for (int i = 0; i < 3; i++) step(S_TRAP, 1'($urandom), 7'($urandom));
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main sequencing FSM of the multicycle RV32I core.
- Each cycle it drives the enables and mux selects for the PC, the instruction register, shared instruction/data memory, register file and ALU.
- Decodes the opcode held in the instruction register.
- Handles a req/ready memory handshake with a wait-timeout; illegal opcodes and memory timeouts go to a sticky trap state.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req may stay high without mem_ready before a bus error; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  7  instruction register bits [6:0]
- zero  in  1  ALU zero flag, valid in the BEQ state
- mem_ready  in  1  memory accepts write / returns read data this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  access is a write
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load enable
- pcwrite  out  1  PC load enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- alusrca  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- alusrcb  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- trap  out  1  sticky; illegal opcode or bus timeout
- trap_cause  out  1  0 = illegal opcode, 1 = bus timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Async reset: state = IDLE, timer = 0, trap = 0, trap_cause = 0. All outputs 0 while in IDLE, state_dbg = 0. IDLE -> FETCH unconditionally.
- Outputs are combinational from state. Only irwrite, pcwrite and retire may depend on mem_ready/zero.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req = 1, adrsrc = 0, alusrca = 00, alusrcb = 10, aluop = 00, resultsrc = 10. irwrite = pcwrite = mem_ready. Stay until mem_ready, then -> DECODE.
- DECODE: alusrca = 01, alusrcb = 01, aluop = 00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other -> TRAP with cause 0
- MEMADR: alusrca = 10, alusrcb = 01, aluop = 00. Load -> MEMREAD, store -> MEMWRITE (opcode[5] distinguishes).
- MEMREAD: mem_req = 1, adrsrc = 1, resultsrc = 00. On mem_ready -> MEMWB.
- MEMWB: resultsrc = 01, regwrite = 1, retire = 1 -> FETCH.
- MEMWRITE: mem_req = 1, memwrite = 1, adrsrc = 1, resultsrc = 00. On mem_ready: retire = 1, -> FETCH.
- EXECR: alusrca = 10, alusrcb = 00, aluop = 10 -> ALUWB.
- EXECI: alusrca = 10, alusrcb = 01, aluop = 10 -> ALUWB.
- JAL: alusrca = 01, alusrcb = 10, aluop = 00, resultsrc = 00, pcwrite = 1 -> ALUWB.
- ALUWB: resultsrc = 00, regwrite = 1, retire = 1 -> FETCH.
- BEQ: alusrca = 10, alusrcb = 00, aluop = 01, resultsrc = 00, pcwrite = zero, retire = 1 -> FETCH.
- TRAP: every enable and mem_req is 0. Stays until reset; trap = 1.
- Timeout timer:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE, and whenever mem_ready = 1.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - Reaching TIMEOUT_CYCLES -> TRAP with cause 1; no write enables are asserted that cycle.
  - If mem_ready rises in the same cycle the timer reaches its limit, mem_ready wins and normal flow continues.
- Reset during a wait or mid-instruction: immediate return to IDLE. No partial enables are held.
- Instruction latencies with zero wait: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles. Each wait cycle adds 1.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum: IDLE = 0, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ, TRAP
  - opcode constants
  - mux-select encodings for resultsrc, alusrca, alusrcb and aluop
- One sub-module, mem_wait_timer: clear/increment counter of width clog2(TIMEOUT_CYCLES + 1) with an expired flag.

Test Plan:
- Reset, mem_ready tied 1, opcode = 0110011. Required:
  - state_dbg sequence IDLE, FETCH, DECODE, EXECR, ALUWB, FETCH
  - irwrite/pcwrite high in the FETCH cycle
  - regwrite and retire high in ALUWB only
- lw (0000011), mem_ready low for 3 cycles in MEMREAD:
  - mem_req = 1 and adrsrc = 1 held 4 cycles
  - MEMWB has resultsrc = 01, regwrite = 1
  - total 8 cycles FETCH to FETCH
- sw (0100011): memwrite = 1 only in MEMWRITE, exactly one retire, regwrite never asserted.
- beq (1100011):
  - zero = 1: pcwrite = 1 in the BEQ cycle
  - zero = 0: pcwrite = 0
  - both cases: aluop = 01, next state FETCH
- Opcode 0000000 -> TRAP after DECODE; trap = 1, trap_cause = 0, all enables 0 for 20 cycles; recovers only on rst.
- TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH -> TRAP after 4 cycles with trap_cause = 1, irwrite never asserted. A rerun with mem_ready pulsed on the 4th cycle proceeds to DECODE.
